// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 8;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StErr
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response and decode handshake bundle.
interface instr_fetch_unit_if;

  logic                           imem_req;
  logic [fetch_pkg::ADDR_W-1:0]   imem_addr;
  logic                           imem_gnt;
  logic                           imem_rvalid;
  logic [fetch_pkg::INSTR_W-1:0]  imem_rdata;
  logic                           instr_valid;
  logic [fetch_pkg::INSTR_W-1:0]  instr;
  logic [fetch_pkg::ADDR_W-1:0]   instr_pc;
  logic                           instr_ready;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  // Memory and decode side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_wdog.sv
// WAIT-state watchdog: counts enabled cycles and flags the LIMIT-th one.
module fetch_wdog
  import fetch_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic CLK,
  input  logic resetl,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LastCnt)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Fires during the LIMIT-th consecutive enabled cycle.
  assign expired = enable && (count_q == LastCnt);

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch FSM with watchdog and sticky error.
// Optional FETCH_MISALIGN_CHECK_EN traps a misaligned NextPC instead of masking it.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [ADDR_W-1:0]  NextPC,
  output logic [ADDR_W-1:0]  CurrentPC,
  output logic               fetch_err,
  instr_fetch_unit_if.master bus
);

  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("TIMEOUT must be in 2..255");
  end

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               req_q;
  logic               valid_q;
  logic               err_q;
  logic               wdog_expired;

  fetch_wdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .CLK     (CLK),
    .resetl  (resetl),
    .clear   (state_q != StWait),
    .enable  (state_q == StWait),
    .expired (wdog_expired)
  );

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StReq;
          req_q   <= 1'b1;
        end
        StReq: begin
          if (bus.imem_gnt) begin
            state_q <= StWait;
            req_q   <= 1'b0;
          end
        end
        StWait: begin
          // Data wins over a timeout landing in the same cycle.
          if (bus.imem_rvalid) begin
            state_q    <= StHold;
            instr_q    <= bus.imem_rdata;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
          end else if (wdog_expired) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end
        end
        StHold: begin
          if (bus.instr_ready) begin
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (NextPC[1:0] != 2'b00) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              pc_q    <= NextPC;
              state_q <= StReq;
              req_q   <= 1'b1;
            end
`else
            pc_q    <= NextPC & ~64'd3;
            state_q <= StReq;
            req_q   <= 1'b1;
`endif
          end
        end
        StErr: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          err_q   <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign CurrentPC       = pc_q;
  assign fetch_err       = err_q;
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scoreboard bench for instr_fetch_unit; honours FETCH_MISALIGN_CHECK_EN.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0;
  localparam int unsigned TMO    = 16;

  logic        CLK    = 1'b0;
  logic        resetl = 1'b0;
  logic [63:0] NextPC = '0;
  logic [63:0] CurrentPC;
  logic        fetch_err;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TMO)
  ) dut (
    .CLK       (CLK),
    .resetl    (resetl),
    .NextPC    (NextPC),
    .CurrentPC (CurrentPC),
    .fetch_err (fetch_err),
    .bus       (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [63:0] pc);
    chk({tag, "_pc"}, CurrentPC, pc);
    chk({tag, "_req"}, 64'(bus.imem_req), 64'd0);
    chk({tag, "_valid"}, 64'(bus.instr_valid), 64'd0);
    chk({tag, "_err"}, 64'(fetch_err), 64'd0);
    chk({tag, "_instr"}, 64'(bus.instr), 64'd0);
    chk({tag, "_ipc"}, bus.instr_pc, 64'd0);
  endtask

  task automatic chk_hold();
    exp_t e;
    chk("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("hold_instr", 64'(bus.instr), 64'(e.instr));
      chk("hold_pc", bus.instr_pc, e.pc);
    end
  endtask

  // Entered at a falling edge with the DUT in REQ; returns at the falling edge
  // after the decode handshake.
  task automatic fetch_one(input int gnt_wait, input int hold_wait, input logic [31:0] word,
                           input logic [63:0] addr, input logic [63:0] nxt);
    chk("req_on", 64'(bus.imem_req), 64'd1);
    chk("req_addr", bus.imem_addr, addr);
    chk("cur_pc", CurrentPC, addr);
    for (int i = 0; i < gnt_wait; i++) begin
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_0000 | 32'(i);
      @(negedge CLK);
      chk("req_held", 64'(bus.imem_req), 64'd1);
      chk("addr_held", bus.imem_addr, addr);
      chk("no_valid_in_req", 64'(bus.instr_valid), 64'd0);
    end
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = ~word;
    sb.push_back('{instr: word, pc: addr});
    @(negedge CLK);
    bus.imem_gnt = 1'b0;
    chk("wait_req_off", 64'(bus.imem_req), 64'd0);
    chk("wait_no_valid", 64'(bus.instr_valid), 64'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = word;
    @(negedge CLK);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0BAD_F00D;
    chk("hold_valid", 64'(bus.instr_valid), 64'd1);
    chk_hold();
    for (int i = 0; i < hold_wait; i++) begin
      bus.instr_ready = 1'b0;
      bus.imem_rvalid = 1'b1;
      NextPC          = {$urandom, $urandom};
      @(negedge CLK);
      chk("stall_valid", 64'(bus.instr_valid), 64'd1);
      chk("stall_instr", 64'(bus.instr), 64'(word));
      chk("stall_ipc", bus.instr_pc, addr);
    end
    bus.imem_rvalid = 1'b0;
    bus.instr_ready = 1'b1;
    NextPC          = nxt;
    @(negedge CLK);
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;

    // Reset values, then first fetch three cycles after release.
    @(negedge CLK);
    @(negedge CLK);
    chk_idle_outputs("rst", RST_PC);
    resetl = 1'b1;
    @(negedge CLK);
    fetch_one(0, 0, 32'h0000_0013, RST_PC, 64'h4);
    fetch_one(0, 0, 32'h0040_0093, 64'h4, 64'h8);

    // Grant stall then decode stall.
    fetch_one(4, 5, 32'h1234_5678, 64'h8, 64'h40);

    // Misaligned NextPC.
    fetch_one(0, 0, 32'hCAFE_0001, 64'h40, 64'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_err", 64'(fetch_err), 64'd1);
    chk("mis_pc", CurrentPC, 64'h40);
    chk("mis_req", 64'(bus.imem_req), 64'd0);
    resetl = 1'b0;
    @(negedge CLK);
    resetl = 1'b1;
    @(negedge CLK);
    fetch_one(0, 0, 32'hCAFE_0002, RST_PC, 64'hFFFF_FFFF_FFFF_FFFC);
`else
    fetch_one(0, 0, 32'hCAFE_0002, 64'h40, 64'hFFFF_FFFF_FFFF_FFFC);
`endif
    fetch_one(0, 0, 32'hCAFE_0003, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100);

    // Reset during WAIT; a late rvalid after release must be ignored.
    bus.imem_gnt = 1'b1;
    @(negedge CLK);
    bus.imem_gnt = 1'b0;
    resetl       = 1'b0;
    #1;
    chk_idle_outputs("rst_wait", RST_PC);
    @(negedge CLK);
    resetl          = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAAD_BAAD;
    @(negedge CLK);
    chk("late_req", 64'(bus.imem_req), 64'd1);
    chk("late_addr", bus.imem_addr, RST_PC);
    @(negedge CLK);
    bus.imem_rvalid = 1'b0;
    chk("late_valid", 64'(bus.instr_valid), 64'd0);
    chk("late_instr", 64'(bus.instr), 64'd0);
    fetch_one(0, 0, 32'h0000_0073, RST_PC, 64'h80);

    // Timeout after TMO silent WAIT cycles, then terminal ERR.
    bus.imem_gnt = 1'b1;
    @(negedge CLK);
    bus.imem_gnt = 1'b0;
    for (int i = 0; i < int'(TMO); i++) begin
      chk("tmo_no_err", 64'(fetch_err), 64'd0);
      @(negedge CLK);
    end
    chk("tmo_err", 64'(fetch_err), 64'd1);
    for (int i = 0; i < 4; i++) begin
      bus.imem_gnt    = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.instr_ready = 1'b1;
      @(negedge CLK);
      chk("err_sticky", 64'(fetch_err), 64'd1);
      chk("err_req", 64'(bus.imem_req), 64'd0);
      chk("err_valid", 64'(bus.instr_valid), 64'd0);
    end
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.instr_ready = 1'b0;
    resetl          = 1'b0;
    @(negedge CLK);
    chk("err_cleared", 64'(fetch_err), 64'd0);
    resetl = 1'b1;
    @(negedge CLK);
    fetch_one(0, 0, 32'h0000_1111, RST_PC, 64'h8);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16: maximum WAIT cycles before fetch error; range 2..255.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 resetl  input  1  asynchronous, active-low reset.
REQ-005 NextPC  input  64  next fetch address from the next-PC logic, sampled on the decode handshake.
REQ-006 CurrentPC  output  64  address of the instruction currently being fetched or held.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  64  request address; equals CurrentPC whenever imem_req=1.
REQ-009 imem_gnt  input  1  memory accepts the request in the same cycle as imem_req=1.
REQ-010 imem_rvalid  input  1  read data valid.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 instr_valid  output  1  the instruction is presented to decode.
REQ-013 instr  output  32  held instruction word.
REQ-014 instr_pc  output  64  PC of the held instruction.
REQ-015 instr_ready  input  1  decode accepts the instruction.
REQ-016 fetch_err  output  1  sticky error flag: timeout, or misalignment when compiled in.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, REQ, WAIT, HOLD, ERR.
REQ-018 IDLE SHALL move to REQ one cycle after reset deassertion.
REQ-019 In REQ, imem_req SHALL be 1, and the FSM SHALL go to WAIT when imem_gnt=1, otherwise stay in REQ with the address stable.
REQ-020 In WAIT, the unit SHALL ignore imem_rvalid in the grant cycle itself, SHALL capture imem_rdata into instr on imem_rvalid=1, and SHALL move to HOLD.
REQ-021 In WAIT, a cycle counter SHALL increment each cycle; reaching TIMEOUT without imem_rvalid SHALL force ERR.
REQ-022 In HOLD, instr_valid SHALL be 1, and instr and instr_pc SHALL be stable until instr_ready=1.
REQ-023 On the HOLD handshake (instr_valid and instr_ready both 1), CurrentPC SHALL load NextPC and the FSM SHALL go to REQ the next cycle.
REQ-024 With imem_gnt tied to 1 and imem_rvalid returned the cycle after grant, the throughput SHALL be one instruction per 3 cycles.
REQ-025 ERR SHALL be terminal until reset: fetch_err=1, imem_req=0, instr_valid=0.
REQ-026 NextPC SHALL be loaded unmodified across the full 64-bit range, including 64'hFFFF_FFFF_FFFF_FFFC; PC wrap is owned by the next-PC logic.
REQ-027 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-028 While resetl=0: state=IDLE, CurrentPC=RESET_PC, instr=0, instr_pc=0, instr_valid=0, imem_req=0, fetch_err=0, counter=0.
REQ-029 Reset assertion mid-transaction (REQ, WAIT or HOLD) SHALL abort the transaction immediately; a late imem_rvalid after reset release SHALL be ignored.

Configuration
REQ-030 With FETCH_MISALIGN_CHECK_EN defined, a handshake with NextPC[1:0]!=0 SHALL go to ERR, set fetch_err, and leave CurrentPC unchanged.
REQ-031 Without FETCH_MISALIGN_CHECK_EN, CurrentPC SHALL load {NextPC[63:2],2'b00}, and only the timeout SHALL set fetch_err.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum, ADDR_W=64, INSTR_W=32, and the default RESET_PC.
REQ-033 The WAIT counter SHALL be one sub-module, fetch_wdog (clear, enable, expired output); everything else stays inline.

Verification
REQ-034 Reset release, RESET_PC=0, gnt=1, rvalid the cycle after grant -> imem_req with addr 0 one cycle after release; instr_valid with instr_pc=0 three cycles after release.
REQ-035 HOLD with instr_ready=0 for 5 cycles, then 1 with NextPC=64'h40 -> instr stable for all 5 cycles; next imem_addr=64'h40.
REQ-036 imem_gnt low for 4 cycles in REQ -> imem_req and imem_addr stay constant; WAIT is entered only on the grant cycle.
REQ-037 No rvalid for TIMEOUT=16 WAIT cycles -> fetch_err=1 and imem_req=0 permanently; resetl pulse -> fetch restarts at RESET_PC.
REQ-038 NextPC=64'h42 on the handshake -> with the macro, ERR and CurrentPC unchanged; without it, the next imem_addr=64'h40.
REQ-039 resetl asserted in WAIT, rvalid arrives 1 cycle after release -> ignored; a fresh request is issued at RESET_PC.
